// File: rtl/counter_mod.sv
// Modulo up/down counter with programmable terminal value, load/clear,
// registered carry/borrow pulses and a sticky one-shot mode.
module counter_mod #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] count_nx;
    logic             carry_nx;
    logic             borrow_nx;
    logic             done_nx;
    logic             up_term;
    logic             dn_term;
    logic             dn_oor;

    assign up_term = (count >= modulus);
    assign dn_term = (count == '0);
    assign dn_oor  = (count > modulus);
    assign tc      = (up && up_term) || (!up && dn_term);

    always_comb begin
        count_nx  = count;
        carry_nx  = 1'b0;
        borrow_nx = 1'b0;
        done_nx   = done;
        if (clear) begin
            count_nx = '0;
            done_nx  = 1'b0;
        end else if (load) begin
            count_nx = load_val;
            done_nx  = 1'b0;
        end else if (en && !done) begin
            if (up) begin
                // Terminal test first, so the increment never overflows.
                if (up_term) begin
                    carry_nx = 1'b1;
                    if (oneshot) begin
                        done_nx = 1'b1;
                    end else begin
                        count_nx = '0;
                    end
                end else begin
                    count_nx = count + WIDTH'(1);
                end
            end else begin
                if (dn_term) begin
                    borrow_nx = 1'b1;
                    if (oneshot) begin
                        done_nx = 1'b1;
                    end else begin
                        count_nx = modulus;
                    end
                end else if (dn_oor) begin
                    count_nx = modulus;
                end else begin
                    count_nx = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            done   <= 1'b0;
        end else begin
            count  <= count_nx;
            carry  <= carry_nx;
            borrow <= borrow_nx;
            done   <= done_nx;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
// Scoreboard bench for counter_mod: driver pushes model expectations,
// monitor pops and compares after every clock edge or reset assertion.
module tb_counter_mod;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] modulus = '0;
    logic         oneshot = 1'b0;
    logic [W-1:0] count;
    logic         carry;
    logic         borrow;
    logic         tc;
    logic         done;

    counter_mod #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up),
        .clear(clear), .load(load), .load_val(load_val),
        .modulus(modulus), .oneshot(oneshot), .count(count),
        .carry(carry), .borrow(borrow), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit cy;
        bit bw;
        bit dn;
        bit t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    int   m_cnt  = 0;
    bit   m_done = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
        end
    endtask

    // Behavioural model of one clock edge, in plain integer arithmetic.
    task automatic model(input bit r, input bit e, input bit u,
                         input bit c, input bit l, input int lv,
                         input int md, input bit os, output exp_t x);
        x.cy = 0;
        x.bw = 0;
        if (!r) begin
            m_cnt  = 0;
            m_done = 0;
        end else if (c) begin
            m_cnt  = 0;
            m_done = 0;
        end else if (l) begin
            m_cnt  = lv;
            m_done = 0;
        end else if (e && !m_done) begin
            if (u) begin
                if (m_cnt >= md) begin
                    x.cy = 1;
                    if (os) m_done = 1;
                    else m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (m_cnt == 0) begin
                    x.bw = 1;
                    if (os) m_done = 1;
                    else m_cnt = md;
                end else if (m_cnt > md) begin
                    m_cnt = md;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
        x.cnt = m_cnt;
        x.dn  = m_done;
        x.t   = (u && m_cnt >= md) || (!u && m_cnt == 0);
    endtask

    task automatic cyc(input bit r, input bit e, input bit u,
                       input bit c, input bit l, input int lv,
                       input int md, input bit os);
        exp_t x;
        @(negedge clk);
        reset    = r;
        en       = e;
        up       = u;
        clear    = c;
        load     = l;
        load_val = W'(lv);
        modulus  = W'(md);
        oneshot  = os;
        model(r, e, u, c, l, lv, md, os, x);
        q.push_back(x);
    endtask

    task automatic async_reset();
        exp_t x;
        @(posedge clk);
        #2;
        m_cnt  = 0;
        m_done = 0;
        x.cnt = 0;
        x.cy  = 0;
        x.bw  = 0;
        x.dn  = 0;
        x.t   = (up && modulus == 0) || !up;
        q.push_back(x);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("count", int'(count), x.cnt);
                chk("carry", int'(carry), int'(x.cy));
                chk("borrow", int'(borrow), int'(x.bw));
                chk("done", int'(done), int'(x.dn));
                chk("tc", int'(tc), int'(x.t));
                chk("carry_borrow_excl", int'(carry & borrow), 0);
            end
        end
    end

    initial begin : driver
        reset = 1'b0;
        cyc(0, 0, 1, 0, 0, 0, 9, 0);
        cyc(0, 0, 1, 0, 0, 0, 9, 0);
        // Wrap up, modulus 9
        for (int i = 0; i < 25; i++) cyc(1, 1, 1, 0, 0, 0, 9, 0);
        // Wrap down from 3, modulus 5
        cyc(1, 0, 0, 0, 1, 3, 5, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0, 5, 0);
        // One-shot up to 4, then reload 0 to resume
        cyc(1, 0, 1, 1, 0, 0, 4, 1);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1, 0, 0, 0, 4, 1);
        cyc(1, 1, 1, 0, 1, 0, 4, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 4, 1);
        // Priority and out-of-range
        cyc(1, 1, 1, 1, 1, 7, 10, 0);
        cyc(1, 0, 1, 0, 1, 200, 10, 0);
        cyc(1, 1, 1, 0, 0, 0, 10, 0);
        cyc(1, 0, 1, 0, 1, 200, 10, 0);
        cyc(1, 1, 0, 0, 0, 0, 10, 0);
        cyc(1, 1, 0, 0, 0, 0, 10, 0);
        // Async reset while count=6 and carry=1 (one-shot terminal)
        cyc(1, 0, 1, 0, 1, 0, 6, 1);
        for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0, 0, 0, 6, 1);
        async_reset();
        cyc(0, 1, 1, 0, 0, 0, 6, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0, 6, 0);
        // modulus 0, both directions
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
        // Full-range wrap
        cyc(1, 0, 1, 0, 1, 254, 255, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 255, 0);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int md;
            md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 7));
            cyc(($urandom_range(0, 60) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 25) == 0),
                ($urandom_range(0, 15) == 0),
                int'($urandom_range(0, 12)),
                md,
                ($urandom_range(0, 5) == 0));
        end
        @(posedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo up/down counter with programmable terminal value, synchronous load/clear, registered wrap pulses and a one-shot mode. It generalises the team's basic free-running counter into a general-purpose timer/divider for prescalers, timeouts and event counting. Carry and borrow pulses are registered so that instances can be cascaded on the same clock.

## Interface
- WIDTH, 8, counter and modulus width in bits (WIDTH >= 2)

- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- en  input  1  count enable, active-high; one step per enabled cycle
- up  input  1  direction: 1 = increment, 0 = decrement
- clear  input  1  synchronous clear, active-high
- load  input  1  synchronous load, active-high
- load_val  input  WIDTH  value written to count on load
- modulus  input  WIDTH  terminal value; legal count range is 0..modulus inclusive
- oneshot  input  1  1 = stop at terminal instead of wrapping
- count  output  WIDTH  current count (registered)
- carry  output  1  one-cycle pulse: up-count wrapped or terminated
- borrow  output  1  one-cycle pulse: down-count wrapped or terminated
- tc  output  1  combinational terminal flag: (up && count >= modulus) || (!up && count == 0)
- done  output  1  sticky one-shot completion flag (registered)

## Operation
- Reset (reset = 0, asynchronous): count = 0, carry = 0, borrow = 0, done = 0. The tc output follows from count.
- Per-edge priority: clear > load > counting.
  - clear: count = 0, done = 0, carry = borrow = 0.
  - load: count = load_val, done = 0, carry = borrow = 0. load_val > modulus is accepted as-is.
  - Counting occurs only when en = 1 and done = 0. Otherwise count holds and carry = borrow = 0.
- Up step:
  - count < modulus: count + 1.
  - count >= modulus (terminal, including out-of-range): count = 0 and carry = 1. In one-shot mode, count holds instead, carry = 1, and done = 1.
- Down step:
  - 0 < count <= modulus: count - 1.
  - count == 0 (terminal): count = modulus and borrow = 1. In one-shot mode, count holds at 0, borrow = 1, and done = 1.
  - count > modulus (out-of-range): count = modulus, no borrow.
- modulus = 0:
  - Up: every enabled cycle is terminal, count stays 0, carry pulses each cycle (divide-by-1).
  - Down: same behaviour, with borrow.
- Arithmetic: unsigned, WIDTH bits. No intermediate overflow can occur because the terminal test precedes the increment. modulus = 2^WIDTH-1 gives a full-range counter.
- Mode or direction change mid-count takes effect on the next enabled edge. No state is reset.
- done is cleared only by clear, load or reset.
  - When done = 1, en is ignored.
  - Changing oneshot to 0 does not clear done.

## Timing
- count, carry, borrow and done update on the rising clk edge.
- Latency: one cycle from en/load/clear sampled to the new count.
- carry and borrow assert in the same cycle that count shows the wrapped/held value, for exactly one cycle per terminal event.
- Cascade: connecting the lower stage's carry to the upper stage's en yields correct chained counting, with the upper stage stepping one cycle after the lower wraps.
- tc is combinational from count, up and modulus. It reflects the current cycle and may be used to predict the next wrap.
- reset deasserts synchronously to clk at the system level. Asserting reset mid-count forces all outputs to their reset values immediately, without waiting for a clock edge.
- carry and borrow are never both 1.

## Test plan
- Wrap up: WIDTH=8, modulus=9, up=1, oneshot=0, en=1 for 25 cycles after reset.
  - Required: count cycles 0..9.
  - carry is high exactly on cycles where count returns to 0 (2 pulses in 20 steps).
  - tc is high while count = 9.
- Wrap down: load_val=3, load, then up=0 with en=1, modulus=5.
  - Required count sequence: 3, 2, 1, 0, 5, 4, …
  - borrow pulses once, in the same cycle that count = 5.
- One-shot: modulus=4, oneshot=1, up=1 from 0, en=1 for 10 cycles.
  - Required: count reaches 4 and holds; carry pulses once; done = 1 thereafter.
  - A subsequent load of 0 clears done and counting resumes.
- Priority and out-of-range:
  - Same edge with clear=1, load=1, load_val=7, en=1: required count = 0.
  - Then load 200 with modulus=10:
    - up step → count 0 and carry = 1.
    - down step from 200 → count 10, no borrow.
- Async reset mid-count: assert reset = 0 between edges while count = 6 and carry = 1.
  - Required: count = 0, carry = 0, done = 0 before the next rising edge.
  - Counting restarts from 0 after release.
- modulus=0, en held high, both directions.
  - Required: count stays 0.
  - carry (up) or borrow (down) is high every cycle.
